// File: rtl/cop0_pkg.sv
// Shared COP0 definitions: register addresses, Status/Cause bit positions,
// exception codes and the exception-sequencer state encoding.
package cop0_pkg;

  localparam logic [4:0] RD_BADVADDR = 5'd8;
  localparam logic [4:0] RD_COUNT    = 5'd9;
  localparam logic [4:0] RD_COMPARE  = 5'd11;
  localparam logic [4:0] RD_STATUS   = 5'd12;
  localparam logic [4:0] RD_CAUSE    = 5'd13;
  localparam logic [4:0] RD_EPC      = 5'd14;
  localparam logic [4:0] RD_EBASE    = 5'd15;

  localparam logic [2:0] SEL_MAIN    = 3'd0;
  localparam logic [2:0] SEL_EBASE   = 3'd1;

  localparam int unsigned ST_IE  = 0;
  localparam int unsigned ST_EXL = 1;
  localparam int unsigned ST_ERL = 2;
  localparam int unsigned CA_TI  = 30;
  localparam int unsigned CA_BD  = 31;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0004;
  localparam logic [31:0] EBASE_RESET  = 32'h8000_0000;
  localparam logic [31:0] EXL_MASK     = 32'h0000_0002;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_MOD  = 5'd1,
    EXC_TLBL = 5'd2,
    EXC_TLBS = 5'd3,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_IBE  = 5'd6,
    EXC_DBE  = 5'd7,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_CPU  = 5'd11,
    EXC_OV   = 5'd12,
    EXC_TR   = 5'd13
  } exc_code_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_EPC    = 3'd1,
    W_BADVA  = 3'd2,
    W_CAUSE  = 3'd3,
    W_STATUS = 3'd4
  } seq_state_e;

  function automatic logic is_reg(input logic [4:0] rd, input logic [2:0] sel,
                                  input logic [4:0] t_rd, input logic [2:0] t_sel);
    return (rd == t_rd) && (sel == t_sel);
  endfunction

endpackage

// File: rtl/cop0_timer.sv
// Count/Compare timer. TI latches when Count reaches Compare and is cleared
// only by a load of Compare. Used when COP0_TIMER_EN is defined.
module cop0_timer
  import cop0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_count,
  input  logic        ld_compare,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic        ti
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;

  always_comb begin
    count_d   = ld_count ? wdata : count_q + 32'd1;
    compare_d = ld_compare ? wdata : compare_q;
    ti_d      = ld_compare ? 1'b0 : (ti_q | (count_q == compare_q));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count = count_q;
  assign ti    = ti_q;

endmodule

// File: rtl/cop0_exception_sequencer.sv
// Sole owner of the COP0 write port: arbitrates exception entry, ERET, MTC0
// and (with COP0_TIMER_EN defined) idle-cycle Count updates.
module cop0_exception_sequencer
  import cop0_pkg::*;
#(
  parameter logic [31:0] EXC_OFFSET = 32'h180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic        exc_badvaddr_valid,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret_valid,
  input  logic        mtc0_valid,
  input  logic [4:0]  mtc0_rd,
  input  logic [2:0]  mtc0_sel,
  input  logic [31:0] mtc0_data,
  input  logic [5:0]  hw_int,
  output logic        cop0_we,
  output logic [4:0]  cop0_write_rd,
  output logic [2:0]  cop0_write_sel,
  output logic [31:0] cop0_din,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        int_pending
);

  // Handshake: exc/eret/mtc0 are taken only in a cycle where the sequencer is
  // IDLE (busy low, W_STATUS excluded); an exception beats ERET beats MTC0.
  // A request presented while not IDLE is not consumed and must be held.

  seq_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  sel_q, sel_d;
  logic [31:0] din_q, din_d;
  logic        redir_q, redir_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [4:0]  code_q, code_d;
  logic        bd_q, bd_d;
  logic        bv_q, bv_d;
  logic [31:0] badva_q, badva_d;
  logic        exl_q, exl_d;
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] ebase_q, ebase_d;
  logic        ti;
  logic [7:0]  live_ip;
  logic [31:0] cause_wr;

`ifdef COP0_TIMER_EN
  logic [31:0] count;
  logic        src_mtc0_q, src_mtc0_d;

  // Only MTC0 writes load the timer; the idle Count refresh must not reload it.
  cop0_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .ld_count   (src_mtc0_q & we_q & is_reg(rd_q, sel_q, RD_COUNT, SEL_MAIN)),
    .ld_compare (src_mtc0_q & we_q & is_reg(rd_q, sel_q, RD_COMPARE, SEL_MAIN)),
    .wdata      (din_q),
    .count      (count),
    .ti         (ti)
  );
`else
  assign ti = 1'b0;
`endif

  // Shadows follow the write currently on the port; their _d values are the
  // up-to-date view used when a new request is decoded.
  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    ebase_d  = ebase_q;
    if (we_q) begin
      if (is_reg(rd_q, sel_q, RD_STATUS, SEL_MAIN)) status_d = din_q;
      if (is_reg(rd_q, sel_q, RD_CAUSE, SEL_MAIN))  cause_d  = din_q;
      if (is_reg(rd_q, sel_q, RD_EPC, SEL_MAIN))    epc_d    = din_q;
      if (is_reg(rd_q, sel_q, RD_EBASE, SEL_EBASE)) ebase_d  = din_q;
    end
  end

  assign live_ip = {ti | hw_int[5], hw_int[4:0], cause_q[9:8]};

  always_comb begin
    cause_wr        = cause_d;
    cause_wr[CA_BD] = exl_q ? cause_d[CA_BD] : bd_q;
    cause_wr[CA_TI] = ti;
    cause_wr[15:8]  = live_ip;
    cause_wr[6:2]   = code_q;
  end

  always_comb begin
    state_d    = state_q;
    we_d       = 1'b0;
    rd_d       = '0;
    sel_d      = '0;
    din_d      = '0;
    redir_d    = 1'b0;
    redir_pc_d = '0;
    code_d     = code_q;
    bd_d       = bd_q;
    bv_d       = bv_q;
    badva_d    = badva_q;
    exl_d      = exl_q;
`ifdef COP0_TIMER_EN
    src_mtc0_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (exc_valid) begin
          state_d = W_EPC;
          code_d  = exc_code;
          bd_d    = exc_bd;
          bv_d    = exc_badvaddr_valid;
          badva_d = exc_badvaddr;
          exl_d   = status_d[ST_EXL];
          // Nested exception: EPC keeps the outer handler's return address.
          we_d    = ~status_d[ST_EXL];
          rd_d    = RD_EPC;
          sel_d   = SEL_MAIN;
          din_d   = exc_bd ? exc_pc - 32'd4 : exc_pc;
        end else if (eret_valid) begin
          we_d       = 1'b1;
          rd_d       = RD_STATUS;
          sel_d      = SEL_MAIN;
          din_d      = status_d & ~EXL_MASK;
          redir_d    = 1'b1;
          redir_pc_d = epc_d;
        end else if (mtc0_valid) begin
          we_d  = 1'b1;
          rd_d  = mtc0_rd;
          sel_d = mtc0_sel;
          din_d = mtc0_data;
`ifdef COP0_TIMER_EN
          src_mtc0_d = 1'b1;
        end else begin
          we_d  = 1'b1;
          rd_d  = RD_COUNT;
          sel_d = SEL_MAIN;
          din_d = count;
`endif
        end
      end
      W_EPC: begin
        we_d  = 1'b1;
        sel_d = SEL_MAIN;
        if (bv_q) begin
          state_d = W_BADVA;
          rd_d    = RD_BADVADDR;
          din_d   = badva_q;
        end else begin
          state_d = W_CAUSE;
          rd_d    = RD_CAUSE;
          din_d   = cause_wr;
        end
      end
      W_BADVA: begin
        state_d = W_CAUSE;
        we_d    = 1'b1;
        rd_d    = RD_CAUSE;
        sel_d   = SEL_MAIN;
        din_d   = cause_wr;
      end
      W_CAUSE: begin
        state_d    = W_STATUS;
        we_d       = 1'b1;
        rd_d       = RD_STATUS;
        sel_d      = SEL_MAIN;
        din_d      = status_d | EXL_MASK;
        redir_d    = 1'b1;
        redir_pc_d = {ebase_d[31:12], 12'h000} + EXC_OFFSET;
      end
      W_STATUS: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      rd_q       <= '0;
      sel_q      <= '0;
      din_q      <= '0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
      code_q     <= '0;
      bd_q       <= 1'b0;
      bv_q       <= 1'b0;
      badva_q    <= '0;
      exl_q      <= 1'b0;
      status_q   <= STATUS_RESET;
      cause_q    <= '0;
      epc_q      <= '0;
      ebase_q    <= EBASE_RESET;
`ifdef COP0_TIMER_EN
      src_mtc0_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      sel_q      <= sel_d;
      din_q      <= din_d;
      redir_q    <= redir_d;
      redir_pc_q <= redir_pc_d;
      code_q     <= code_d;
      bd_q       <= bd_d;
      bv_q       <= bv_d;
      badva_q    <= badva_d;
      exl_q      <= exl_d;
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      ebase_q    <= ebase_d;
`ifdef COP0_TIMER_EN
      src_mtc0_q <= src_mtc0_d;
`endif
    end
  end

  assign cop0_we        = we_q;
  assign cop0_write_rd  = rd_q;
  assign cop0_write_sel = sel_q;
  assign cop0_din       = din_q;
  assign redirect_valid = redir_q;
  assign redirect_pc    = redir_pc_q;
  // The W_STATUS cycle already reports not-busy so the next request lands right after it.
  assign busy           = (state_q != IDLE) && (state_q != W_STATUS);
  assign int_pending    = status_q[ST_IE] & ~status_q[ST_EXL] & ~status_q[ST_ERL] &
                          (|(status_q[15:8] & live_ip));

endmodule

// File: tb/tb_cop0_exception_sequencer.sv
// Directed bench for cop0_exception_sequencer; timer cases compile in only
// when COP0_TIMER_EN is defined.
module tb_cop0_exception_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        exc_badvaddr_valid;
  logic [31:0] exc_badvaddr;
  logic        eret_valid;
  logic        mtc0_valid;
  logic [4:0]  mtc0_rd;
  logic [2:0]  mtc0_sel;
  logic [31:0] mtc0_data;
  logic [5:0]  hw_int;
  logic        cop0_we;
  logic [4:0]  cop0_write_rd;
  logic [2:0]  cop0_write_sel;
  logic [31:0] cop0_din;
  logic        busy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        int_pending;

  int cmp_count = 0;
  int err_count = 0;
  logic [39:0] exp_q[$];

  cop0_exception_sequencer #(.EXC_OFFSET(32'h180)) dut (
    .clk                (clk),
    .reset              (reset),
    .exc_valid          (exc_valid),
    .exc_code           (exc_code),
    .exc_pc             (exc_pc),
    .exc_bd             (exc_bd),
    .exc_badvaddr_valid (exc_badvaddr_valid),
    .exc_badvaddr       (exc_badvaddr),
    .eret_valid         (eret_valid),
    .mtc0_valid         (mtc0_valid),
    .mtc0_rd            (mtc0_rd),
    .mtc0_sel           (mtc0_sel),
    .mtc0_data          (mtc0_data),
    .hw_int             (hw_int),
    .cop0_we            (cop0_we),
    .cop0_write_rd      (cop0_write_rd),
    .cop0_write_sel     (cop0_write_sel),
    .cop0_din           (cop0_din),
    .busy               (busy),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .int_pending        (int_pending)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_count++;
    if (obs !== exp) begin
      err_count++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    exc_valid          = 1'b0;
    exc_code           = '0;
    exc_pc             = '0;
    exc_bd             = 1'b0;
    exc_badvaddr_valid = 1'b0;
    exc_badvaddr       = '0;
    eret_valid         = 1'b0;
    mtc0_valid         = 1'b0;
    mtc0_rd            = '0;
    mtc0_sel           = '0;
    mtc0_data          = '0;
  endtask

  task automatic drive_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                           input logic bv, input logic [31:0] va);
    exc_valid          = 1'b1;
    exc_code           = code;
    exc_pc             = pc;
    exc_bd             = bd;
    exc_badvaddr_valid = bv;
    exc_badvaddr       = va;
  endtask

  task automatic drive_mtc0(input logic [4:0] rd, input logic [2:0] sel, input logic [31:0] data);
    mtc0_valid = 1'b1;
    mtc0_rd    = rd;
    mtc0_sel   = sel;
    mtc0_data  = data;
  endtask

  // Scoreboard
  task automatic push_wr(input logic [4:0] rd, input logic [2:0] sel, input logic [31:0] din);
    exp_q.push_back({rd, sel, din});
  endtask

  task automatic check_wr(input string tag);
    logic [39:0] e;
    check({tag, "_queued"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_port"}, {23'd0, cop0_we, cop0_write_rd, cop0_write_sel}, {23'd0, 1'b1, e[39:32]});
      check({tag, "_din"}, cop0_din, e[31:0]);
    end
  endtask

  task automatic check_idle(input string tag);
`ifdef COP0_TIMER_EN
    check({tag, "_count_wr"}, {23'd0, cop0_we, cop0_write_rd, cop0_write_sel}, {23'd0, 1'b1, 5'd9, 3'd0});
`else
    check({tag, "_we"}, 32'(cop0_we), 32'd0);
`endif
  endtask

  task automatic check_redirect(input string tag, input logic [31:0] pc);
    check({tag, "_rv"}, 32'(redirect_valid), 32'd1);
    check({tag, "_pc"}, redirect_pc, pc);
  endtask

  initial begin
    clear_inputs();
    hw_int = '0;
    reset  = 1'b1;
    step();
    step();
    check("rst_we", 32'(cop0_we), 32'd0);
    check("rst_rd", 32'(cop0_write_rd), 32'd0);
    check("rst_sel", 32'(cop0_write_sel), 32'd0);
    check("rst_din", cop0_din, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rv", 32'(redirect_valid), 32'd0);
    check("rst_rpc", redirect_pc, 32'd0);
    check("rst_intp", 32'(int_pending), 32'd0);
    reset = 1'b0;
    step();
`ifdef COP0_TIMER_EN
    // Count==Compare==0 out of reset sets TI; park Compare far away.
    drive_mtc0(5'd11, 3'd0, 32'hFFFF_0000);
    step();
    clear_inputs();
    push_wr(5'd11, 3'd0, 32'hFFFF_0000);
    check_wr("park_compare");
    step();
`endif

    // Exception with BadVAddr: four writes, redirect with Status
    drive_exc(5'd4, 32'h8000_1000, 1'b0, 1'b1, 32'h0000_1235);
    push_wr(5'd14, 3'd0, 32'h8000_1000);
    push_wr(5'd8, 3'd0, 32'h0000_1235);
    push_wr(5'd13, 3'd0, 32'h0000_0010);
    push_wr(5'd12, 3'd0, 32'h0040_0006);
    step();
    clear_inputs();
    check_wr("exc1_epc");
    check("exc1_busy", 32'(busy), 32'd1);
    check("exc1_rv_early", 32'(redirect_valid), 32'd0);
    step();
    check_wr("exc1_badva");
    step();
    check_wr("exc1_cause");
    step();
    check_wr("exc1_status");
    check_redirect("exc1_redir", 32'h8000_0180);
    check("exc1_busy_fall", 32'(busy), 32'd0);
    step();
    check_idle("exc1_after");
    check("exc1_rv_done", 32'(redirect_valid), 32'd0);

    // ERET clears EXL and returns to EPC
    eret_valid = 1'b1;
    push_wr(5'd12, 3'd0, 32'h0040_0004);
    step();
    clear_inputs();
    check_wr("eret1");
    check_redirect("eret1_redir", 32'h8000_1000);
    step();

    // Delay-slot exception, no BadVAddr: redirect on the third cycle
    drive_exc(5'd10, 32'h8000_0008, 1'b1, 1'b0, 32'h0);
    push_wr(5'd14, 3'd0, 32'h8000_0004);
    push_wr(5'd13, 3'd0, 32'h8000_0028);
    push_wr(5'd12, 3'd0, 32'h0040_0006);
    step();
    clear_inputs();
    check_wr("exc2_epc");
    step();
    check_wr("exc2_cause");
    step();
    check_wr("exc2_status");
    check_redirect("exc2_redir", 32'h8000_0180);
    step();

    // Nested exception with EXL=1: no EPC write, BD kept
    drive_exc(5'd8, 32'h8000_2000, 1'b0, 1'b0, 32'h0);
    step();
    clear_inputs();
    check("exc3_epc_we", 32'(cop0_we), 32'd0);
    check("exc3_busy", 32'(busy), 32'd1);
    push_wr(5'd13, 3'd0, 32'h8000_0020);
    push_wr(5'd12, 3'd0, 32'h0040_0006);
    step();
    check_wr("exc3_cause");
    step();
    check_wr("exc3_status");
    check_redirect("exc3_redir", 32'h8000_0180);
    step();

    // MTC0 Status with EXL set masks the interrupt until ERET
    hw_int = 6'b000001;
    drive_mtc0(5'd12, 3'd0, 32'h0000_FF03);
    push_wr(5'd12, 3'd0, 32'h0000_FF03);
    step();
    clear_inputs();
    check_wr("mtc0_status");
    check("mtc0_rv", 32'(redirect_valid), 32'd0);
    step();
    check("intp_exl_masked", 32'(int_pending), 32'd0);
    eret_valid = 1'b1;
    push_wr(5'd12, 3'd0, 32'h0000_FF01);
    step();
    clear_inputs();
    check_wr("eret2");
    check_redirect("eret2_redir", 32'h8000_0004);
    step();
    check("intp_on", 32'(int_pending), 32'd1);
    hw_int = 6'b000000;
    #1;
    check("intp_off", 32'(int_pending), 32'd0);
    hw_int = 6'b000001;

    // Exception and ERET together; MTC0 offered while busy
    drive_exc(5'd12, 32'h8000_3000, 1'b0, 1'b0, 32'h0);
    eret_valid = 1'b1;
    push_wr(5'd14, 3'd0, 32'h8000_3000);
    step();
    clear_inputs();
    check_wr("exc4_epc");
    drive_mtc0(5'd12, 3'd0, 32'hDEAD_BEEF);
    push_wr(5'd13, 3'd0, 32'h0000_0430);
    push_wr(5'd12, 3'd0, 32'h0000_FF03);
    step();
    check_wr("exc4_cause");
    step();
    clear_inputs();
    check_wr("exc4_status");
    check_redirect("exc4_redir", 32'h8000_0180);
    step();
    check_idle("exc4_after");
    check("exc4_eret_dropped", 32'(redirect_valid), 32'd0);
    eret_valid = 1'b1;
    push_wr(5'd12, 3'd0, 32'h0000_FF01);
    step();
    clear_inputs();
    check_wr("eret3");
    check_redirect("eret3_redir", 32'h8000_3000);
    step();

    // Reset in the middle of a sequence
    hw_int = '0;
    drive_exc(5'd4, 32'h8000_6000, 1'b0, 1'b1, 32'h0000_0040);
    step();
    clear_inputs();
    check("midrst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    check("midrst_we", 32'(cop0_we), 32'd0);
    check("midrst_busy_clr", 32'(busy), 32'd0);
    check("midrst_rv", 32'(redirect_valid), 32'd0);
    reset = 1'b0;
    step();
    check_idle("midrst_after");
    check("midrst_rv_after", 32'(redirect_valid), 32'd0);
    eret_valid = 1'b1;
    push_wr(5'd12, 3'd0, 32'h0040_0004);
    step();
    clear_inputs();
    check_wr("eret_rst_shadow");
    check_redirect("eret_rst_redir", 32'h0000_0000);
    step();

`ifdef COP0_TIMER_EN
    // Timer: Compare=20, Count=10, TI visible in the next exception's Cause
    drive_mtc0(5'd11, 3'd0, 32'd20);
    push_wr(5'd11, 3'd0, 32'd20);
    step();
    check_wr("tmr_compare");
    drive_mtc0(5'd9, 3'd0, 32'd10);
    push_wr(5'd9, 3'd0, 32'd10);
    step();
    clear_inputs();
    check_wr("tmr_count");
    for (int i = 0; i < 15; i++) step();
    drive_exc(5'd0, 32'h8000_4000, 1'b0, 1'b0, 32'h0);
    push_wr(5'd14, 3'd0, 32'h8000_4000);
    push_wr(5'd13, 3'd0, 32'h4000_8000);
    push_wr(5'd12, 3'd0, 32'h0040_0006);
    step();
    clear_inputs();
    check_wr("tmr_exc_epc");
    step();
    check_wr("tmr_exc_cause");
    step();
    check_wr("tmr_exc_status");
    step();
    drive_mtc0(5'd11, 3'd0, 32'd100);
    push_wr(5'd11, 3'd0, 32'd100);
    step();
    clear_inputs();
    check_wr("tmr_compare_clr");
    step();
    drive_exc(5'd8, 32'h8000_5000, 1'b0, 1'b0, 32'h0);
    step();
    clear_inputs();
    check("tmr_exc2_epc_we", 32'(cop0_we), 32'd0);
    push_wr(5'd13, 3'd0, 32'h0000_0020);
    push_wr(5'd12, 3'd0, 32'h0040_0006);
    step();
    check_wr("tmr_exc2_cause");
    step();
    check_wr("tmr_exc2_status");
    step();
`endif

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
